// File: rtl/scope_trigger_capture.sv
// ---------------------------------------------------------------------------
// scope_trigger_capture
//
// Purpose:
//   Oscilloscope-style capture block for the 12-bit sample stream. After an
//   arm request it fills PRETRIG samples of history, then watches for a
//   level/slope crossing while overwriting a circular RAM. Once triggered it
//   records the rest of the window and streams all DEPTH samples out
//   oldest-first over a valid/ready interface. One capture per arm.
//
// Optional feature:
//   SCOPE_AUTO_TRIG_EN - when defined, a trigger is forced on the AUTO_TMO-th
//   sample seen while waiting for a trigger, and o_auto_fired reports it.
//   When undefined the block waits for a real trigger indefinitely.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   i_sample_vld   sample strobe
//   i_sample_in    sample data (unsigned)
//   i_arm          start a capture (honoured only when idle)
//   i_trig_level   trigger threshold, latched on accepted arm
//   i_trig_slope   0 = rising, 1 = falling, latched on accepted arm
//   o_busy         high whenever a capture is in progress
//   o_trig_pulse   high in the cycle the trigger sample is written
//   o_auto_fired   capture was force-triggered by the timeout
//   o_out_valid    o_out_data holds a captured sample
//   i_out_ready    downstream accepts the sample
//   o_out_data     captured sample, oldest first
//   o_out_last     marks the final sample of the window
// ---------------------------------------------------------------------------
module scope_trigger_capture #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 10,
  parameter int PRETRIG  = 128,
  parameter int AUTO_TMO = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_sample_vld,
  input  logic [DATA_W-1:0] i_sample_in,
  input  logic              i_arm,
  input  logic [DATA_W-1:0] i_trig_level,
  input  logic              i_trig_slope,
  output logic              o_busy,
  output logic              o_trig_pulse,
  output logic              o_auto_fired,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFILL, S_WAIT_TRIG, S_POSTFILL, S_READOUT
  } state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, r_trig_addr, r_cnt;
  logic [ADDR_W:0]   r_issue_cnt, r_load_cnt;
  logic [DATA_W-1:0] r_level, r_prev;
  logic              r_slope, r_prev_vld, r_pend;

  logic w_accept, w_track, w_cross, w_real_trig, w_auto_trig, w_trig;
  logic w_arm_ok, w_pre_done, w_post_done, w_hs, w_load, w_issue, w_done;

  // Samples are only taken while filling; IDLE and READOUT drop them.
  assign w_accept    = i_sample_vld && (r_state == S_PREFILL || r_state == S_WAIT_TRIG ||
                                        r_state == S_POSTFILL);
  assign w_track     = i_sample_vld && (r_state == S_PREFILL || r_state == S_WAIT_TRIG);
  assign w_cross     = r_prev_vld && (r_slope ? (r_prev > r_level && i_sample_in <= r_level)
                                              : (r_prev < r_level && i_sample_in >= r_level));
  assign w_real_trig = w_accept && (r_state == S_WAIT_TRIG) && w_cross;
  assign w_trig      = w_real_trig || w_auto_trig;
  assign w_arm_ok    = i_arm && (r_state == S_IDLE);
  assign w_pre_done  = w_accept && (r_state == S_PREFILL) && (r_cnt == PRE_LAST);
  assign w_post_done = w_accept && (r_state == S_POSTFILL) && (r_cnt == POST_LAST);

  // Readout is a two-stage pipe: RAM read into r_ram_q (r_pend marks it
  // full), then into the output register. A new read is issued whenever
  // the RAM stage is empty or is being emptied this cycle.
  assign w_hs    = o_out_valid && i_out_ready;
  assign w_load  = r_pend && (!o_out_valid || w_hs);
  assign w_issue = (r_state == S_READOUT) && (r_issue_cnt != CNT_DEPTH) && (!r_pend || w_load);
  assign w_done  = w_hs && o_out_last;

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int             TMO_W    = $clog2(AUTO_TMO) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TMO - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_auto_fired;

  // A real crossing on the timeout sample wins, so auto_fired stays low.
  assign w_auto_trig  = w_accept && (r_state == S_WAIT_TRIG) && (r_tmo_cnt == TMO_LAST) && !w_cross;
  assign o_auto_fired = r_auto_fired;

  // Timeout counter of samples seen while waiting; flag held until re-arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt    <= '0;
      r_auto_fired <= 1'b0;
    end else if (w_arm_ok) begin
      r_tmo_cnt    <= '0;
      r_auto_fired <= 1'b0;
    end else begin
      if (w_accept && r_state == S_WAIT_TRIG) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_auto_trig) r_auto_fired <= 1'b1;
    end
  end
`else
  // No timeout in this build: the forced trigger can never occur.
  assign w_auto_trig  = 1'b0 && (AUTO_TMO > 0);
  assign o_auto_fired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_busy       = (r_state != S_IDLE);
    o_trig_pulse = w_trig;
    case (r_state)
      S_IDLE:      if (w_arm_ok)    w_next = S_PREFILL;
      S_PREFILL:   if (w_pre_done)  w_next = S_WAIT_TRIG;
      S_WAIT_TRIG: if (w_trig)      w_next = S_POSTFILL;
      S_POSTFILL:  if (w_post_done) w_next = S_READOUT;
      S_READOUT:   if (w_done)      w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  // Capture RAM: single write port, registered read port for readout.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= i_sample_in;
    if (w_issue)  r_ram_q <= r_mem[r_rd_ptr];
  end

  // Pointers, trigger tracking and the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_trig_addr <= '0;
      r_cnt       <= '0;
      r_issue_cnt <= '0;
      r_load_cnt  <= '0;
      r_level     <= '0;
      r_prev      <= '0;
      r_slope     <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_pend      <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_last  <= 1'b0;
    end else begin
      if (w_arm_ok) begin
        r_level    <= i_trig_level;
        r_slope    <= i_trig_slope;
        r_prev_vld <= 1'b0;
        r_cnt      <= '0;
        r_wr_ptr   <= '0;
      end
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_track) begin
        r_prev     <= i_sample_in;
        r_prev_vld <= 1'b1;
      end
      if (w_accept && (r_state == S_PREFILL || r_state == S_POSTFILL))
        r_cnt <= w_pre_done ? '0 : r_cnt + 1'b1;
      if (w_trig) begin
        r_trig_addr <= r_wr_ptr;
        r_cnt       <= '0;
      end
      if (w_post_done) begin
        r_rd_ptr    <= r_trig_addr - PRE_OFS;
        r_issue_cnt <= '0;
        r_load_cnt  <= '0;
        r_pend      <= 1'b0;
      end
      if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_issue_cnt <= r_issue_cnt + 1'b1;
        r_pend      <= 1'b1;
      end else if (w_load) begin
        r_pend <= 1'b0;
      end
      if (w_load) begin
        o_out_data  <= r_ram_q;
        o_out_valid <= 1'b1;
        o_out_last  <= (r_load_cnt == CNT_DEPTH - 1'b1);
        r_load_cnt  <= r_load_cnt + 1'b1;
      end else if (w_hs) begin
        o_out_valid <= 1'b0;
        o_out_last  <= 1'b0;
      end
    end
  end

endmodule
